// File: rtl/calc_seq_engine.sv
// rtl/calc_seq_engine.sv - sequential calculator: stage sequencing, operand capture, iterative ALU
module calc_seq_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     sw_value,
  input  logic [2:0]           sw_opcode,
  input  logic                 next_pulse,
  input  logic                 prev_pulse,
  input  logic                 chain_pulse,
  output logic [2:0]           stage,
  output logic                 store_num1,
  output logic                 store_num2,
  output logic                 store_op,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   answer,
  output logic                 answer_valid,
  output logic                 is_negative,
  output logic                 div_by_zero
);

  typedef enum logic [2:0] {
    S_NUM1 = 3'd0,
    S_NUM2 = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam int AW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] num1, num2, rem;
  logic [2:0]       opcode;
  logic [CNT_W-1:0] cnt;

  logic             next_ok, prev_ok, iterative, zero_div, calc_done;
  logic [AW-1:0]    a_ext, b_ext, alu_result, mul_sum, quot_next;
  logic             mul_bit, div_bit, div_ge;
  logic [CNT_W-1:0] div_idx;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;

  // Pulse qualification, single-cycle ALU and one step of the shift-add / restoring-divide units
  always_comb begin
    next_ok    = next_pulse & ~prev_pulse;
    prev_ok    = prev_pulse & ~next_pulse;
    iterative  = (opcode == 3'b010) || (opcode == 3'b011) || (opcode == 3'b100);
    zero_div   = ((opcode == 3'b011) || (opcode == 3'b100)) && (num2 == '0);
    calc_done  = !iterative || zero_div || (cnt == LAST);
    a_ext      = {{WIDTH{1'b0}}, num1};
    b_ext      = {{WIDTH{1'b0}}, num2};
    alu_result = '0;
    case (opcode)
      3'b000:  alu_result = a_ext + b_ext;
      3'b001:  alu_result = (num1 >= num2) ? (a_ext - b_ext) : (b_ext - a_ext);
      3'b101:  alu_result = a_ext & b_ext;
      3'b110:  alu_result = a_ext | b_ext;
      3'b111:  alu_result = a_ext ^ b_ext;
      default: alu_result = '0;
    endcase
    // Multiplier bit cnt (LSB first) selects whether num1 << cnt is accumulated
    mul_bit   = |(num2 & (WIDTH'(1) << cnt));
    mul_sum   = answer + (mul_bit ? (a_ext << cnt) : '0);
    // Dividend bit WIDTH-1-cnt (MSB first) is shifted into the partial remainder
    div_idx   = LAST - cnt;
    div_bit   = |(num1 & (WIDTH'(1) << div_idx));
    trial     = {rem, div_bit};
    div_ge    = trial >= {1'b0, num2};
    rem_next  = div_ge ? WIDTH'(trial - {1'b0, num2}) : trial[WIDTH-1:0];
    quot_next = {answer[AW-2:0], div_ge};
  end

  // Stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_NUM1;
    else     state <= state_next;
  end

  // Next-stage decode; pulses are not looked at during CALC, chain wins in SHOW
  always_comb begin
    state_next = state;
    case (state)
      S_NUM1: if (next_ok) state_next = S_NUM2;
      S_NUM2: begin
        if (next_ok)      state_next = S_OP;
        else if (prev_ok) state_next = S_NUM1;
      end
      S_OP: begin
        if (next_ok)      state_next = S_CALC;
        else if (prev_ok) state_next = S_NUM2;
      end
      S_CALC: if (calc_done) state_next = S_SHOW;
      S_SHOW: begin
        if (chain_pulse)  state_next = S_NUM2;
        else if (next_ok) state_next = S_NUM1;
        else if (prev_ok) state_next = S_OP;
      end
      default: state_next = S_NUM1;
    endcase
  end

  // Operand capture, iterative arithmetic and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num1        <= '0;
      num2        <= '0;
      opcode      <= '0;
      cnt         <= '0;
      rem         <= '0;
      answer      <= '0;
      is_negative <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_NUM1: if (next_ok) num1 <= sw_value;
        S_NUM2: if (next_ok) num2 <= sw_value;
        S_OP: begin
          if (next_ok) begin
            opcode      <= sw_opcode;
            cnt         <= '0;
            rem         <= '0;
            answer      <= '0;
            is_negative <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (zero_div) begin
            answer      <= '0;
            div_by_zero <= 1'b1;
          end else begin
            case (opcode)
              3'b010: answer <= mul_sum;
              3'b011: begin
                answer <= quot_next;
                rem    <= rem_next;
              end
              3'b100: begin
                rem    <= rem_next;
                answer <= (cnt == LAST) ? {{WIDTH{1'b0}}, rem_next} : quot_next;
              end
              3'b001: begin
                answer      <= alu_result;
                is_negative <= (num1 < num2);
              end
              default: answer <= alu_result;
            endcase
          end
        end
        S_SHOW: begin
          if (chain_pulse) begin
            num1        <= answer[WIDTH-1:0];
            answer      <= '0;
            is_negative <= 1'b0;
            div_by_zero <= 1'b0;
          end else if (next_ok) begin
            answer      <= '0;
            is_negative <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stage        = state;
  assign store_num1   = (state == S_NUM1);
  assign store_num2   = (state == S_NUM2);
  assign store_op     = (state == S_OP);
  assign busy         = (state == S_CALC);
  assign answer_valid = (state == S_SHOW);

endmodule

// File: tb/tb_calc_seq_engine.sv
// tb/tb_calc_seq_engine.sv - scoreboard bench for calc_seq_engine
module tb_calc_seq_engine;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  sw_value;
  logic [2:0]    sw_opcode;
  logic          next_pulse, prev_pulse, chain_pulse;
  logic [2:0]    stage;
  logic          store_num1, store_num2, store_op, busy;
  logic [2*W-1:0] answer;
  logic          answer_valid, is_negative, div_by_zero;

  calc_seq_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sw_value(sw_value), .sw_opcode(sw_opcode),
    .next_pulse(next_pulse), .prev_pulse(prev_pulse), .chain_pulse(chain_pulse),
    .stage(stage), .store_num1(store_num1), .store_num2(store_num2), .store_op(store_op),
    .busy(busy), .answer(answer), .answer_valid(answer_valid),
    .is_negative(is_negative), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*W-1:0] ans;
    logic           neg;
    logic           dz;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   mnum1, mnum2;
  logic [2*W-1:0] mans;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on unsigned operands
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    exp_t e;
    longint unsigned ua = a, ub = b;
    e = '0;
    case (op)
      3'd0: e.ans = (2*W)'(ua + ub);
      3'd1: begin
        if (ua >= ub) e.ans = (2*W)'(ua - ub);
        else begin e.ans = (2*W)'(ub - ua); e.neg = 1'b1; end
      end
      3'd2: e.ans = (2*W)'(ua * ub);
      3'd3: if (ub == 0) e.dz = 1'b1; else e.ans = (2*W)'(ua / ub);
      3'd4: if (ub == 0) e.dz = 1'b1; else e.ans = (2*W)'(ua % ub);
      3'd5: e.ans = (2*W)'(ua & ub);
      3'd6: e.ans = (2*W)'(ua | ub);
      default: e.ans = (2*W)'(ua ^ ub);
    endcase
    return e;
  endfunction

  function automatic int latency(input logic [W-1:0] b, input logic [2:0] op);
    if (op == 3'd2) return W;
    if ((op == 3'd3 || op == 3'd4) && b != 0) return W;
    return 1;
  endfunction

  // Monitor: each rise of answer_valid consumes one expected result
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (answer_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: result 0x%0h with no expected entry at %0t", answer, $time);
        end else begin
          e = sb.pop_front();
          chk("answer", 64'(answer), 64'(e.ans));
          chk("is_negative", 64'(is_negative), 64'(e.neg));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        end
      end
      prev_valid = answer_valid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic pulse(input logic n, input logic p, input logic c);
    next_pulse = n; prev_pulse = p; chain_pulse = c;
    @(negedge clk);
    next_pulse = 0; prev_pulse = 0; chain_pulse = 0;
  endtask

  task automatic enter_num1(input logic [W-1:0] a);
    sw_value = a;
    pulse(1, 0, 0);
    mnum1 = a;
    sw_value = W'($urandom);
  endtask

  task automatic enter_num2(input logic [W-1:0] b);
    sw_value = b;
    pulse(1, 0, 0);
    mnum2 = b;
    sw_value = W'($urandom);
  endtask

  task automatic enter_op(input logic [2:0] op, input bit inject);
    exp_t e;
    int cyc;
    e = model(mnum1, mnum2, op);
    mans = e.ans;
    sb.push_back(e);
    sw_opcode = op;
    pulse(1, 0, 0);
    sw_opcode = 3'($urandom);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (inject) begin
        next_pulse = cyc[0]; prev_pulse = ~cyc[0]; chain_pulse = cyc[1];
      end
      @(negedge clk);
    end
    next_pulse = 0; prev_pulse = 0; chain_pulse = 0;
    chk("calc_cycles", 64'(cyc), 64'(latency(mnum2, op)));
    chk("stage_show", 64'(stage), 64'd4);
  endtask

  task automatic show_next();
    pulse(1, 0, 0);
    chk("stage_after_next", 64'(stage), 64'd0);
    chk("answer_cleared", 64'(answer), 64'd0);
    chk("flags_cleared", 64'({is_negative, div_by_zero}), 64'd0);
  endtask

  initial begin : stim
    rst = 1'b1; sw_value = '0; sw_opcode = '0;
    next_pulse = 0; prev_pulse = 0; chain_pulse = 0;
    repeat (2) @(negedge clk);
    chk("rst_stage", 64'(stage), 64'd0);
    chk("rst_answer", 64'(answer), 64'd0);
    chk("rst_outs", 64'({store_num1, store_num2, store_op, busy, answer_valid, is_negative, div_by_zero}), 64'b1000000);
    rst = 1'b0;
    @(negedge clk);

    pulse(0, 1, 0);
    chk("num1_prev_stays", 64'(stage), 64'd0);

    enter_num1(16'h1234); enter_num2(16'h0F0F); enter_op(3'd0, 0); show_next();
    enter_num1(16'd5);    enter_num2(16'd9);    enter_op(3'd1, 0); show_next();
    enter_num1(16'hFFFF); enter_num2(16'hFFFF); enter_op(3'd2, 1); show_next();

    enter_num1(16'd100); enter_num2(16'd7); enter_op(3'd3, 0);
    pulse(0, 1, 0);
    chk("show_prev_to_op", 64'(stage), 64'd2);
    enter_op(3'd4, 0);
    show_next();

    enter_num1(16'd5); enter_num2(16'd0); enter_op(3'd3, 0); show_next();

    enter_num1(16'h8000); enter_num2(16'd4); enter_op(3'd2, 0);
    pulse(1, 0, 1);
    chk("chain_stage", 64'(stage), 64'd1);
    chk("chain_answer_cleared", 64'(answer), 64'd0);
    mnum1 = mans[W-1:0];
    pulse(1, 1, 0);
    chk("next_prev_ignored", 64'(stage), 64'd1);
    pulse(0, 1, 0);
    chk("num2_prev_to_num1", 64'(stage), 64'd0);
    pulse(1, 0, 0);
    mnum1 = sw_value;
    enter_num2(16'd3); enter_op(3'd0, 0); show_next();

    enter_num1(16'hABCD); enter_num2(16'h1234);
    sw_opcode = 3'd2;
    pulse(1, 0, 0);
    repeat (6) @(negedge clk);
    chk("mid_mul_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_stage", 64'(stage), 64'd0);
    chk("abort_answer", 64'(answer), 64'd0);
    chk("abort_flags", 64'({busy, answer_valid, is_negative, div_by_zero}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    enter_num1(16'h00FF); enter_num2(16'h0101); enter_op(3'd0, 0); show_next();

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 12));
      enter_num1(a); enter_num2(b); enter_op(3'($urandom_range(0, 7)), 0);
      if (i % 4 == 3) begin
        pulse(1, 0, 1);
        chk("rand_chain_stage", 64'(stage), 64'd1);
        mnum1 = mans[W-1:0];
        enter_num2(W'($urandom));
        enter_op(3'($urandom_range(0, 7)), 0);
      end
      show_next();
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
